// File: rtl/bus_pkg.sv
// Shared types and requester indices for the memory bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_DATA   = 1;
    localparam int REQ_DBG    = 2;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 3,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [PW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port; one transaction at a time,
// grant held until memory completes or the access times out.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             r,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  err,
    output logic [DW-1:0]    rdata,
    output logic [NREQ-1:0]  gnt,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    input  logic             mem_ready
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t      state, state_nx;
    logic [PW-1:0]   ptr, owner;
    logic [TW-1:0]   tcnt;
    logic [NREQ-1:0] pick_onehot;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic            start, finish_ok, finish_to;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or posedge r) begin
        if (r) state <= IDLE;
        else   state <= state_nx;
    end

    // mem_ready takes priority over the timeout when both land in one cycle
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    start    = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    finish_ok = 1'b1;
                    state_nx  = DONE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    finish_to = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            ptr       <= '0;
            owner     <= '0;
            tcnt      <= '0;
            gnt       <= '0;
            ack       <= '0;
            err       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            if (start) begin
                gnt       <= pick_onehot;
                owner     <= pick_idx;
                mem_req   <= 1'b1;
                mem_we    <= req_we[pick_idx];
                mem_addr  <= req_addr[pick_idx*AW +: AW];
                mem_wdata <= req_wdata[pick_idx*DW +: DW];
                tcnt      <= '0;
            end
            if (state == ACCESS) tcnt <= tcnt + 1'b1;
            if (finish_ok) begin
                rdata   <= mem_rdata;
                ack     <= gnt;
                mem_req <= 1'b0;
            end
            if (finish_to) begin
                err     <= gnt;
                mem_req <= 1'b0;
            end
            if (state == DONE) begin
                gnt <= '0;
                ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

endmodule
